// File: rtl/tl_pkg.sv
// Shared TileLink opcodes and the D-beat bundle
// used by the instruction-memory responder.
package tl_pkg;

  localparam logic [2:0] TL_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_GET           = 3'd4;
  localparam logic [2:0] TL_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } d_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WACK
  } state_e;

endpackage

// File: rtl/tl_resp_skid.sv
// Two-entry fall-through FIFO feeding the D channel;
// the head is held stable while the master stalls.
module tl_resp_skid
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  d_beat_t    push_beat,
  input  logic       d_ready,
  output logic       d_valid,
  output d_beat_t    head,
  output logic       fire,
  output logic [1:0] count
);

  d_beat_t    mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;
  logic       empty;
  logic       store;
  logic       deq;

  assign empty   = (cnt_q == 2'd0);
  assign d_valid = !empty || push;
  assign head    = empty ? push_beat : mem_q[rd_q];
  assign fire    = d_valid && d_ready;
  assign count   = cnt_q;

  // An empty FIFO hands a same-cycle push straight through.
  assign store = push && !(empty && d_ready);
  assign deq   = fire && !empty;

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_q] <= push_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (store) wr_q <= ~wr_q;
      if (deq)   rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, store} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/tl_imem_responder.sv
// TileLink-UH responder for icache refills (Get bursts)
// and program loading (single-beat Puts) over a word SRAM.
module tl_imem_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          MAX_LG_SIZE = 6,
  localparam int         AW          = $clog2(MEM_WORDS)
) (
  input  logic          core_clock_i,
  input  logic          core_reset_i,
  input  logic [2:0]    a_opcode_i,
  input  logic [2:0]    a_param_i,
  input  logic [3:0]    a_size_i,
  input  logic [31:0]   a_address_i,
  input  logic [3:0]    a_mask_i,
  input  logic [31:0]   a_data_i,
  input  logic          a_corrupt_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  output logic [2:0]    d_opcode_o,
  output logic [1:0]    d_param_o,
  output logic [3:0]    d_size_o,
  output logic          d_denied_o,
  output logic [31:0]   d_data_o,
  output logic          d_corrupt_o,
  output logic          d_valid_o,
  input  logic          d_ready_i,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [3:0]  MAX_SZ = 4'(MAX_LG_SIZE);
  localparam logic [32:0] LIMIT  =
    {1'b0, MEM_BASE} + 33'(MEM_WORDS) * 33'd4;

  state_e        state_q, state_d;
  logic [3:0]    size_q;
  logic [AW-1:0] woff_q;
  logic [3:0]    mask_q;
  logic [31:0]   data_q;
  logic          corrupt_q;
  logic          denied_q;
  logic [13:0]   beats_q;
  logic [13:0]   issued_q;
  logic [13:0]   popped_q;
  logic          inflight_q;
  logic          wfirst_q;

  logic          a_fire;
  logic          is_get;
  logic          is_put;
  logic [31:0]   low_mask;
  logic [32:0]   end_addr;
  logic [31:0]   off;
  logic          deny;
  logic [13:0]   nbeats;
  logic [1:0]    occ;
  logic          issue;
  logic          rd_en;
  logic          wr_en;
  logic          live;
  logic          push;
  d_beat_t       push_beat;
  d_beat_t       sk_head;
  d_beat_t       d_out;
  logic          sk_valid;
  logic          sk_fire;
  logic [1:0]    sk_count;
  logic          unused_ok;

  assign a_fire   = a_valid_i && (state_q == ST_IDLE);
  assign is_get   = (a_opcode_i == TL_GET);
  assign is_put   = (a_opcode_i == TL_PUTFULL)
                 || (a_opcode_i == TL_PUTPARTIAL);
  assign low_mask = 32'((33'd1 << a_size_i) - 33'd1);
  assign end_addr = {1'b0, a_address_i} + (33'd1 << a_size_i);
  assign off      = a_address_i - MEM_BASE;
  assign nbeats   = (a_size_i < 4'd2) ? 14'd1
                  : 14'd1 << (a_size_i - 4'd2);

  assign deny = !(is_get || is_put)
             || (a_size_i > MAX_SZ)
             || (is_put && a_size_i > 4'd2)
             || (|(a_address_i & low_mask))
             || (a_address_i < MEM_BASE)
             || (end_addr > LIMIT);

  // Denied Gets still pace through the issue slot, just without an SRAM read.
  assign occ   = sk_count + {1'b0, inflight_q};
  assign issue = (state_q == ST_READ) && (issued_q < beats_q)
              && (occ < 2'd2);
  assign rd_en = issue && !denied_q;
  assign wr_en = (state_q == ST_WACK) && wfirst_q
              && !denied_q && !corrupt_q;
  assign push  = inflight_q || ((state_q == ST_WACK) && wfirst_q);

  always_comb begin
    push_beat        = '0;
    push_beat.size   = size_q;
    push_beat.denied = denied_q;
    if (inflight_q) begin
      push_beat.opcode  = TL_ACCESSACKDATA;
      push_beat.corrupt = denied_q;
      push_beat.data    = denied_q ? 32'h0 : mem_rdata_i;
    end else begin
      push_beat.opcode  = TL_ACCESSACK;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (a_fire) state_d = is_put ? ST_WACK : ST_READ;
      ST_READ: if (sk_fire && popped_q == beats_q - 14'd1)
                 state_d = ST_IDLE;
      ST_WACK: if (sk_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      woff_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      corrupt_q  <= 1'b0;
      denied_q   <= 1'b0;
      beats_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wfirst_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      wfirst_q   <= a_fire && is_put;
      if (a_fire) begin
        size_q    <= a_size_i;
        woff_q    <= off[AW+1:2];
        mask_q    <= a_mask_i;
        data_q    <= a_data_i;
        corrupt_q <= a_corrupt_i;
        denied_q  <= deny;
        beats_q   <= nbeats;
        issued_q  <= '0;
        popped_q  <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 14'd1;
        if (sk_fire && state_q == ST_READ)
          popped_q <= popped_q + 14'd1;
      end
    end
  end

  tl_resp_skid u_skid (
    .clk       (core_clock_i),
    .rst       (core_reset_i),
    .push      (push),
    .push_beat (push_beat),
    .d_ready   (d_ready_i),
    .d_valid   (sk_valid),
    .head      (sk_head),
    .fire      (sk_fire),
    .count     (sk_count)
  );

  // Every output is forced low while reset is held.
  assign live        = !core_reset_i;
  assign a_ready_o   = live && (state_q == ST_IDLE);
  assign d_out       = live ? sk_head : '0;
  assign d_valid_o   = live && sk_valid;
  assign d_opcode_o  = d_out.opcode;
  assign d_param_o   = 2'b00;
  assign d_size_o    = d_out.size;
  assign d_denied_o  = d_out.denied;
  assign d_corrupt_o = d_out.corrupt;
  assign d_data_o    = d_out.data;

  assign mem_en_o    = live && (rd_en || wr_en);
  assign mem_we_o    = (live && wr_en) ? mask_q : 4'b0;
  assign mem_addr_o  = (live && (rd_en || wr_en))
                     ? woff_q + AW'(issued_q) : '0;
  assign mem_wdata_o = (live && wr_en) ? data_q : 32'h0;

  assign unused_ok = ^{a_param_i, off[1:0], off[31:AW+2]};

endmodule

// File: tb/tb_tl_imem_responder.sv
// Vector-table bench for tl_imem_responder with an SRAM model,
// a shadow-memory scoreboard and reset/stall corner sequences.
module tb_tl_imem_responder;
  import tl_pkg::*;

  localparam int MW = 4096;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    a_opcode = '0;
  logic [2:0]    a_param = '0;
  logic [3:0]    a_size = '0;
  logic [31:0]   a_address = '0;
  logic [3:0]    a_mask = '0;
  logic [31:0]   a_data = '0;
  logic          a_corrupt = 1'b0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [3:0]    d_size;
  logic          d_denied;
  logic [31:0]   d_data;
  logic          d_corrupt;
  logic          d_valid;
  logic          d_ready = 1'b1;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  tl_imem_responder #(
    .MEM_BASE    (32'h0),
    .MEM_WORDS   (MW),
    .MAX_LG_SIZE (6)
  ) dut (
    .core_clock_i (clk),
    .core_reset_i (rst),
    .a_opcode_i   (a_opcode),
    .a_param_i    (a_param),
    .a_size_i     (a_size),
    .a_address_i  (a_address),
    .a_mask_i     (a_mask),
    .a_data_i     (a_data),
    .a_corrupt_i  (a_corrupt),
    .a_valid_i    (a_valid),
    .a_ready_o    (a_ready),
    .d_opcode_o   (d_opcode),
    .d_param_o    (d_param),
    .d_size_o     (d_size),
    .d_denied_o   (d_denied),
    .d_data_o     (d_data),
    .d_corrupt_o  (d_corrupt),
    .d_valid_o    (d_valid),
    .d_ready_i    (d_ready),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // SRAM model, preloaded with word i = i and word 2 = 0x11223344
  logic [31:0] ram [MW];
  bit          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < MW; i++) ram[i] <= 32'(i);
      ram[2] <= 32'h1122_3344;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we == 4'b0) mem_rdata <= ram[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records D handshakes and tallies SRAM traffic
  logic [40:0] obs [1024];
  logic [40:0] d_now;
  logic [40:0] prev_d = '0;
  bit          stalled = 1'b0;
  int beats_tot = 0, mem_tot = 0, rd_tot = 0, pop_tot = 0;
  int dv_tot = 0, stall_bad = 0, max_out = 0;
  int first_v = 0, last_hs = 0, seen_seq = 0;
  int arm_seq = 0;
  bit track = 1'b0;
  bit tgl = 1'b0;

  assign d_now = {d_opcode, d_size, d_denied, d_corrupt, d_data};

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (mem_en) mem_tot++;
      if (mem_en && mem_we == 4'b0) rd_tot++;
      if (d_valid) dv_tot++;
      if (d_valid && seen_seq != arm_seq) begin
        first_v  = cyc;
        seen_seq = arm_seq;
      end
      if (stalled && (!d_valid || d_now != prev_d)) stall_bad++;
      if (d_valid && d_ready) begin
        obs[beats_tot % 1024] = d_now;
        beats_tot++;
        last_hs = cyc;
        if (d_opcode == TL_ACCESSACKDATA && !d_denied) pop_tot++;
      end
      if (track && rd_tot - pop_tot > max_out) max_out = rd_tot - pop_tot;
      stalled = d_valid && !d_ready;
      prev_d  = d_now;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      d_ready = tgl ? ~d_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  opc;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        cor;
    logic        tgl;
    logic        den;
    int          nb;
  } vec_t;

  vec_t        vt [15];
  logic [31:0] shadow [MW];
  logic [40:0] sbq [$];
  int errs = 0, checks = 0;
  int rd_idx = 0;
  int acc_cyc = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drain();
    logic [40:0] got;
    while (rd_idx < beats_tot) begin
      got = obs[rd_idx % 1024];
      rd_idx++;
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL extra_beat: got %h, none expected", got);
      end else begin
        chk("d_beat", got, sbq.pop_front());
      end
    end
  endtask

  task automatic send(input vec_t v);
    int g = 0;
    @(negedge clk);
    #1;
    a_opcode  = v.opc;
    a_param   = 3'd7;
    a_size    = v.size;
    a_address = v.addr;
    a_mask    = v.mask;
    a_data    = v.data;
    a_corrupt = v.cor;
    a_valid   = 1'b1;
    while (!a_ready && g < 100) begin
      @(negedge clk);
      #1;
      drain();
      g++;
    end
    if (!a_ready) begin
      checks++;
      errs++;
      $display("FAIL a_accept: got a_ready 0, expected 1");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_done(input int nb, input int b0);
    int g = 0;
    while (beats_tot - b0 < nb && g < 5000) begin
      @(negedge clk);
      #1;
      drain();
      g++;
    end
    chk("beat_count", beats_tot - b0, nb);
    @(negedge clk);
    #1;
    drain();
    chk("a_ready_after", a_ready, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic run_vec(input vec_t v, input bit lat);
    int  b0 = beats_tot;
    int  m0 = mem_tot;
    int  s0 = stall_bad;
    int  w;
    bit  put;
    logic [40:0] e;
    put = (v.opc == TL_PUTFULL) || (v.opc == TL_PUTPARTIAL);
    tgl = v.tgl;
    for (int i = 0; i < v.nb; i++) begin
      if (put) e = {TL_ACCESSACK, v.size, v.den, 1'b0, 32'h0};
      else begin
        w = int'(v.addr[13:2]) + i;
        e = {TL_ACCESSACKDATA, v.size, v.den, v.den,
             v.den ? 32'h0 : shadow[w]};
      end
      sbq.push_back(e);
    end
    if (put && !v.den && !v.cor) begin
      w = int'(v.addr[13:2]);
      for (int b = 0; b < 4; b++)
        if (v.mask[b]) shadow[w][8*b +: 8] = v.data[8*b +: 8];
    end
    arm_seq++;
    send(v);
    wait_done(v.nb, b0);
    chk("mem_ops", mem_tot - m0,
        (v.den || (put && v.cor)) ? 0 : (put ? 1 : v.nb));
    chk("stall_stable", stall_bad - s0, 0);
    if (lat) begin
      chk("first_latency", first_v - acc_cyc, 2);
      chk("burst_span", last_hs - first_v, v.nb - 1);
    end
  endtask

  initial begin
    int b0;
    int dv0;
    int m0;
    vt[0]  = '{3'd4, 4'd6, 32'h40,   4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 16};
    vt[1]  = '{3'd4, 4'd6, 32'h40,   4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 16};
    vt[2]  = '{3'd1, 4'd2, 32'h8,    4'h5, 32'hAABBCCDD,  1'b0, 1'b0, 1'b0, 1};
    vt[3]  = '{3'd4, 4'd2, 32'h8,    4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1};
    vt[4]  = '{3'd4, 4'd6, 32'h44,   4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 16};
    vt[5]  = '{3'd4, 4'd2, 32'h4000, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1};
    vt[6]  = '{3'd5, 4'd2, 32'h0,    4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1};
    vt[7]  = '{3'd0, 4'd2, 32'h10,   4'hF, 32'hCAFEBABE,  1'b1, 1'b0, 1'b0, 1};
    vt[8]  = '{3'd4, 4'd2, 32'h10,   4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1};
    vt[9]  = '{3'd0, 4'd3, 32'h20,   4'hF, 32'h1234,      1'b0, 1'b0, 1'b1, 1};
    vt[10] = '{3'd4, 4'd0, 32'h13,   4'h1, 32'h0,         1'b0, 1'b0, 1'b0, 1};
    vt[11] = '{3'd4, 4'd7, 32'h0,    4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 32};
    vt[12] = '{3'd0, 4'd2, 32'h3FFC, 4'hF, 32'h12345678,  1'b0, 1'b0, 1'b0, 1};
    vt[13] = '{3'd4, 4'd6, 32'h3FC0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 16};
    vt[14] = '{3'd4, 4'd3, 32'h3FF8, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 2};
    for (int i = 0; i < MW; i++) shadow[i] = 32'(i);
    shadow[2] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        |{a_ready, d_valid, d_opcode, d_param, d_size, d_denied,
          d_data, d_corrupt, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("a_ready_post_reset", a_ready, 1);

    for (int i = 0; i < 15; i++) begin
      track = (i == 1);
      run_vec(vt[i], i == 0);
      if (i == 1) chk("max_outstanding", max_out <= 2, 1);
    end
    track = 1'b0;
    tgl   = 1'b0;

    // Reset in the middle of a 16-beat refill
    b0 = beats_tot;
    for (int i = 0; i < 16; i++)
      sbq.push_back({TL_ACCESSACKDATA, 4'd6, 1'b0, 1'b0,
                     shadow[16 + i]});
    arm_seq++;
    send(vt[0]);
    for (int g = 0; g < 200 && beats_tot - b0 < 5; g++) begin
      @(negedge clk);
      #1;
      drain();
    end
    chk("beats_before_reset", beats_tot - b0, 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_reset_outputs",
        |{a_ready, d_valid, d_opcode, d_param, d_size, d_denied,
          d_data, d_corrupt, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("a_ready_after_mid_reset", a_ready, 1);
    dv0 = dv_tot;
    m0  = mem_tot;
    repeat (20) @(negedge clk);
    #1;
    drain();
    chk("no_beats_after_reset", dv_tot - dv0, 0);
    chk("no_mem_after_reset", mem_tot - m0, 0);
    run_vec(vt[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
